// File: rtl/caf_peak_select.sv
// Frame-wide CAF peak tracker: scans one result per frequency bin, then holds the
// single peak (magnitude, lag index, bin) on a valid/ready output until consumed.
module caf_peak_select #(
  parameter int unsigned out_max_bits        = 5,
  parameter int unsigned length_counter_bits = 3,
  parameter int unsigned freq_bins           = 8,
  parameter int unsigned freq_bin_bits       = 3
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           m_axis_tvalid,
  input  logic [out_max_bits-1:0]        out_max,
  input  logic [length_counter_bits-1:0] index,
  output logic                           s_axis_tready,
  input  logic                           m_axis_tready,
  output logic [out_max_bits-1:0]        peak_max,
  output logic [length_counter_bits-1:0] peak_index,
  output logic [freq_bin_bits-1:0]       peak_bin,
  output logic                           s_axis_tvalid
);

  localparam logic [0:0] S_COLLECT = 1'b0;
  localparam logic [0:0] S_HOLD    = 1'b1;

  localparam logic [freq_bin_bits-1:0] LastBin = freq_bin_bits'(freq_bins - 1);

  logic [0:0]                     state_q, state_d;
  logic [freq_bin_bits-1:0]       bin_q, bin_d;
  logic [out_max_bits-1:0]        run_max_q, run_max_d;
  logic [length_counter_bits-1:0] run_idx_q, run_idx_d;
  logic [freq_bin_bits-1:0]       run_bin_q, run_bin_d;
  logic [out_max_bits-1:0]        peak_max_q, peak_max_d;
  logic [length_counter_bits-1:0] peak_idx_q, peak_idx_d;
  logic [freq_bin_bits-1:0]       peak_bin_q, peak_bin_d;
  logic                           tvalid_q, tvalid_d;
  logic                           tready_q, tready_d;
  logic                           take_new;

  // State and datapath registers; tready comes out of reset high so COLLECT accepts at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_COLLECT;
      bin_q      <= '0;
      run_max_q  <= '0;
      run_idx_q  <= '0;
      run_bin_q  <= '0;
      peak_max_q <= '0;
      peak_idx_q <= '0;
      peak_bin_q <= '0;
      tvalid_q   <= 1'b0;
      tready_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      run_max_q  <= run_max_d;
      run_idx_q  <= run_idx_d;
      run_bin_q  <= run_bin_d;
      peak_max_q <= peak_max_d;
      peak_idx_q <= peak_idx_d;
      peak_bin_q <= peak_bin_d;
      tvalid_q   <= tvalid_d;
      tready_q   <= tready_d;
    end
  end

  // Next-state: bin 0 seeds the candidate, later bins replace it only on a strict win
  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    run_max_d  = run_max_q;
    run_idx_d  = run_idx_q;
    run_bin_d  = run_bin_q;
    peak_max_d = peak_max_q;
    peak_idx_d = peak_idx_q;
    peak_bin_d = peak_bin_q;
    tvalid_d   = tvalid_q;
    tready_d   = tready_q;
    take_new   = 1'b0;

    case (state_q)
      S_COLLECT: begin
        if (m_axis_tvalid && tready_q) begin
          take_new = (bin_q == '0) || (out_max > run_max_q);
          if (take_new) begin
            run_max_d = out_max;
            run_idx_d = index;
            run_bin_d = bin_q;
          end
          if (bin_q == LastBin) begin
            // Publish the candidate including this last sample
            peak_max_d = run_max_d;
            peak_idx_d = run_idx_d;
            peak_bin_d = run_bin_d;
            bin_d      = '0;
            tvalid_d   = 1'b1;
            tready_d   = 1'b0;
            state_d    = S_HOLD;
          end else begin
            bin_d = bin_q + freq_bin_bits'(1);
          end
        end
      end
      S_HOLD: begin
        if (m_axis_tready) begin
          tvalid_d = 1'b0;
          tready_d = 1'b1;
          state_d  = S_COLLECT;
        end
      end
      default: begin
        state_d  = S_COLLECT;
        tvalid_d = 1'b0;
        tready_d = 1'b1;
      end
    endcase
  end

  assign s_axis_tready = tready_q;
  assign s_axis_tvalid = tvalid_q;
  assign peak_max      = peak_max_q;
  assign peak_index    = peak_idx_q;
  assign peak_bin      = peak_bin_q;

endmodule

// File: tb/tb_caf_peak_select.sv
// Scoreboard bench for caf_peak_select: stimulus pushes the expected peak per frame,
// a monitor pops and compares on every output handshake.
module tb_caf_peak_select;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       m_axis_tvalid;
  logic [4:0] out_max;
  logic [2:0] index;
  logic       s_axis_tready;
  logic       m_axis_tready;
  logic [4:0] peak_max;
  logic [2:0] peak_index;
  logic [2:0] peak_bin;
  logic       s_axis_tvalid;

  int errors = 0;
  int checks = 0;
  int outputs_seen = 0;
  int outputs_expected = 0;

  logic [10:0] exp_q[$];

  always #5 clk = ~clk;

  caf_peak_select #(
    .out_max_bits(5), .length_counter_bits(3), .freq_bins(8), .freq_bin_bits(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .m_axis_tvalid(m_axis_tvalid), .out_max(out_max),
    .index(index), .s_axis_tready(s_axis_tready), .m_axis_tready(m_axis_tready),
    .peak_max(peak_max), .peak_index(peak_index), .peak_bin(peak_bin),
    .s_axis_tvalid(s_axis_tvalid)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: a handshake completes on the next rising edge whenever valid & ready here
  always @(negedge clk) begin
    if (rst_n && s_axis_tvalid && m_axis_tready) begin
      logic [10:0] e;
      outputs_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_output", {21'd0, peak_max, peak_index, peak_bin}, 32'hFFFFFFFF);
      end else begin
        e = exp_q.pop_front();
        check("peak_tuple", {21'd0, peak_max, peak_index, peak_bin}, {21'd0, e});
      end
    end
  end

  task automatic send(input logic [4:0] m, input logic [2:0] ix);
    logic ok;
    m_axis_tvalid = 1'b1;
    out_max = m;
    index = ix;
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = s_axis_tready;
      @(posedge clk);
      #1;
    end
    if (!ok) check("send_timeout", 32'd0, 32'd1);
    m_axis_tvalid = 1'b0;
  endtask

  task automatic send_frame(input logic [4:0] m[8], input logic [2:0] ix[8], input int max_gap);
    for (int b = 0; b < 8; b++) begin
      send(m[b], ix[b]);
      if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) begin @(posedge clk); #1; end
    end
  endtask

  function automatic logic [10:0] ref_peak(input logic [4:0] m[8], input logic [2:0] ix[8]);
    logic [4:0] bm;
    logic [2:0] bi, bb;
    bm = m[0]; bi = ix[0]; bb = 3'd0;
    for (int b = 1; b < 8; b++)
      if (m[b] > bm) begin bm = m[b]; bi = ix[b]; bb = 3'(b); end
    return {bm, bi, bb};
  endfunction

  task automatic expect_peak(input logic [10:0] e);
    exp_q.push_back(e);
    outputs_expected++;
  endtask

  logic [4:0] m2[8]   = '{5'd3, 5'd7, 5'd2, 5'd9, 5'd9, 5'd1, 5'd0, 5'd4};
  logic [2:0] ixb[8]  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
  logic [4:0] m0[8]   = '{default: 5'd0};
  logic [2:0] ix3[8]  = '{3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7, 3'd6};
  logic [4:0] m5[8]   = '{5'd1, 5'd30, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd31};
  logic [4:0] m6a[8]  = '{5'd8, 5'd8, 5'd8, 5'd20, 5'd1, 5'd20, 5'd19, 5'd2};
  logic [4:0] m6b[8]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd1};
  logic [4:0] m6c[8]  = '{5'd31, 5'd31, 5'd0, 5'd31, 5'd5, 5'd6, 5'd7, 5'd30};
  logic [2:0] ix6[8]  = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};

  initial begin
    rst_n = 1'b0;
    m_axis_tvalid = 1'b0;
    out_max = '0;
    index = '0;
    m_axis_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: idle after reset
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("idle_state", {s_axis_tready, s_axis_tvalid, peak_max, peak_index, peak_bin},
            {1'b1, 1'b0, 11'd0});
    end
    @(posedge clk); #1;

    // 2: basic frame, tie keeps the earlier bin
    expect_peak({5'd9, 3'd3, 3'd3});
    send_frame(m2, ixb, 0);
    repeat (3) begin @(posedge clk); #1; end

    // 3: all-zero frame seeds from bin 0
    expect_peak({5'd0, 3'd5, 3'd0});
    send_frame(m0, ix3, 0);
    repeat (3) begin @(posedge clk); #1; end

    // 4: backpressure holds the result, extra input ignored
    m_axis_tready = 1'b0;
    expect_peak({5'd9, 3'd3, 3'd3});
    send_frame(m2, ixb, 0);
    m_axis_tvalid = 1'b1;
    out_max = 5'd31;
    index = 3'd7;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("hold_stable", {s_axis_tready, s_axis_tvalid, peak_max, peak_index, peak_bin},
            {1'b0, 1'b1, 5'd9, 3'd3, 3'd3});
      @(posedge clk); #1;
    end
    m_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    @(posedge clk); #1;
    check("release_valid", {31'd0, s_axis_tvalid}, 32'd0);
    check("release_ready", {31'd0, s_axis_tready}, 32'd1);

    // 5: reset mid-frame discards partial data
    for (int b = 0; b < 4; b++) send(5'd25, 3'(b));
    rst_n = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset", {s_axis_tready, s_axis_tvalid, peak_max, peak_index, peak_bin},
          {1'b1, 1'b0, 11'd0});
    @(posedge clk); #1;
    expect_peak({5'd31, 3'd7, 3'd7});
    send_frame(m5, ixb, 0);
    repeat (3) begin @(posedge clk); #1; end

    // 6: back-to-back frames with random idle gaps
    expect_peak(ref_peak(m6a, ix6));
    send_frame(m6a, ix6, 3);
    expect_peak(ref_peak(m6b, ix6));
    send_frame(m6b, ix6, 2);
    expect_peak(ref_peak(m6c, ixb));
    send_frame(m6c, ixb, 3);
    expect_peak(ref_peak(m2, ixb));
    send_frame(m2, ixb, 0);

    for (int c = 0; c < 100 && exp_q.size() != 0; c++) begin @(posedge clk); #1; end
    repeat (3) begin @(posedge clk); #1; end
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("output_count", 32'(outputs_seen), 32'(outputs_expected));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
